seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 24 ++
 rtl/seq_alu_if.sv | 28 ++
 rtl/seq_alu_mul.sv | 58 +++++
 rtl/seq_alu.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared constants for the sequential ALU: opcodes, flag bit positions, FSM encoding.
package seq_alu_pkg;

    localparam int unsigned OPER_W = 3;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned ST_W   = 2;

    localparam logic [OPER_W-1:0] OP_SUB       = 3'b000;
    localparam logic [OPER_W-1:0] OP_NAND      = 3'b001;
    localparam logic [OPER_W-1:0] OP_START_ONE = 3'b010;
    localparam logic [OPER_W-1:0] OP_ONEHOT2U2 = 3'b011;
    localparam logic [OPER_W-1:0] OP_ADD       = 3'b100;
    localparam logic [OPER_W-1:0] OP_MUL       = 3'b101;

    localparam int unsigned FLAG_ERR      = 0;
    localparam int unsigned FLAG_NEG      = 1;
    localparam int unsigned FLAG_POS      = 2;
    localparam int unsigned FLAG_OVERFLOW = 3;

    localparam logic [ST_W-1:0] ST_IDLE = 2'b00;
    localparam logic [ST_W-1:0] ST_BUSY = 2'b01;
    localparam logic [ST_W-1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bus of the sequential ALU; master drives requests and the result-ready.
interface seq_alu_if
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) ();

    logic [WIDTH-1:0]  i_arg0;
    logic [WIDTH-1:0]  i_arg1;
    logic [OPER_W-1:0] i_oper;
    logic              i_valid;
    logic              o_ready;
    logic [WIDTH-1:0]  o_result;
    logic [FLAG_W-1:0] o_flag;
    logic              o_valid;
    logic              i_ready;

    modport master (
        output i_arg0, i_arg1, i_oper, i_valid, i_ready,
        input  o_ready, o_result, o_flag, o_valid
    );

    modport slave (
        input  i_arg0, i_arg1, i_oper, i_valid, i_ready,
        output o_ready, o_result, o_flag, o_valid
    );

endinterface

// File: rtl/seq_alu_mul.sv
// Iterative signed shift-add multiplier: operands loaded on i_start, one multiplier bit per
// cycle; o_done_c/o_prod_c present the final 2*WIDTH product during the last iteration.
module seq_alu_mul #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic               o_done_c,
    output logic [2*WIDTH-1:0] o_prod_c
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    logic              r_busy;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [PW-1:0]     r_acc;
    logic              w_last;
    logic [PW-1:0]     w_addend;
    logic [PW-1:0]     w_acc_nxt;

    // The multiplier MSB carries negative weight, so the last partial product is subtracted.
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    assign w_addend  = r_mplier[0] ? (w_last ? (-r_mcand) : r_mcand) : '0;
    assign w_acc_nxt = r_acc + w_addend;
    assign o_done_c  = r_busy && w_last;
    assign o_prod_c  = w_acc_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= {{WIDTH{i_a[WIDTH-1]}}, i_a};
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_busy) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake and result backpressure.
// Define SEQ_ALU_MUL_EN to build the iterative MUL; otherwise opcode 101 is reserved.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic     i_clk,
    input  logic     i_rst,
    seq_alu_if.slave bus
);

    logic [ST_W-1:0]   r_state;
    logic [ST_W-1:0]   w_state_nxt;
    logic [WIDTH-1:0]  r_result;
    logic [FLAG_W-1:0] r_flag;
    logic              r_valid;
    logic              w_accept;
    logic              w_is_mul;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH:0]    w_diff;
    logic [WIDTH-1:0]  w_res;
    logic              w_ovf;
    logic              w_err;
    logic [FLAG_W-1:0] w_flag;

    function automatic logic [WIDTH-1:0] f_starting_ones(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] cnt;
        logic             run;
        cnt = '0;
        run = 1'b1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            run = run & a[i];
            cnt = cnt + WIDTH'(run);
        end
        return cnt;
    endfunction

    function automatic logic [WIDTH-1:0] f_popcount(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + WIDTH'(a[i]);
        end
        return cnt;
    endfunction

    function automatic logic [WIDTH-1:0] f_onehot_idx(input logic [WIDTH-1:0] a);
        logic [WIDTH-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) begin
                idx = WIDTH'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [FLAG_W-1:0] f_flags(input logic [WIDTH-1:0] res, input logic ovf);
        logic [FLAG_W-1:0] f;
        f                = '0;
        f[FLAG_NEG]      = res[WIDTH-1];
        f[FLAG_POS]      = !res[WIDTH-1] && (res != '0);
        f[FLAG_OVERFLOW] = ovf;
        return f;
    endfunction

    assign w_accept = bus.i_valid && (r_state == ST_IDLE);
    assign w_sum    = {bus.i_arg0[WIDTH-1], bus.i_arg0} + {bus.i_arg1[WIDTH-1], bus.i_arg1};
    assign w_diff   = {bus.i_arg0[WIDTH-1], bus.i_arg0} - {bus.i_arg1[WIDTH-1], bus.i_arg1};

    // Single-cycle datapath; MUL lands in the reserved branch and is overridden when enabled.
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_err = 1'b0;
        case (bus.i_oper)
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_ovf = w_diff[WIDTH] ^ w_diff[WIDTH-1];
            end
            OP_NAND:      w_res = ~(bus.i_arg0 & bus.i_arg1);
            OP_START_ONE: w_res = f_starting_ones(bus.i_arg0);
            OP_ONEHOT2U2: begin
                if (f_popcount(bus.i_arg0) == WIDTH'(1)) begin
                    w_res = f_onehot_idx(bus.i_arg0);
                end else begin
                    w_err = 1'b1;
                end
            end
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
            end
            default: w_err = 1'b1;
        endcase
        w_flag = f_flags(w_res, w_ovf);
        if (w_err) begin
            w_flag           = '0;
            w_flag[FLAG_ERR] = 1'b1;
        end
    end

`ifdef SEQ_ALU_MUL_EN
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_ovf;

    assign w_is_mul = (bus.i_oper == OP_MUL);

    seq_alu_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (w_accept && w_is_mul),
        .i_a      (bus.i_arg0),
        .i_b      (bus.i_arg1),
        .o_done_c (w_mul_done),
        .o_prod_c (w_prod)
    );

    // Product fits in WIDTH bits only if its upper half plus the result MSB are a sign extension.
    assign w_mul_ovf = !((&w_prod[2*WIDTH-1:WIDTH-1]) || (~|w_prod[2*WIDTH-1:WIDTH-1]));
`else
    assign w_is_mul = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_is_mul ? ST_BUSY : ST_DONE;
                end
            end
`ifdef SEQ_ALU_MUL_EN
            ST_BUSY: begin
                if (w_mul_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (bus.i_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result registers only load on completion, so they hold through backpressure.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_result <= '0;
            r_flag   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_accept && !w_is_mul) begin
                r_result <= w_res;
                r_flag   <= w_flag;
            end
`ifdef SEQ_ALU_MUL_EN
            else if (w_mul_done) begin
                r_result <= w_prod[WIDTH-1:0];
                r_flag   <= f_flags(w_prod[WIDTH-1:0], w_mul_ovf);
            end
`endif
            r_valid <= (w_state_nxt == ST_DONE);
        end
    end

    assign bus.o_ready  = (r_state == ST_IDLE);
    assign bus.o_result = r_result;
    assign bus.o_flag   = r_flag;
    assign bus.o_valid  = r_valid;

endmodule
